// File: rtl/fetch_sequencer_pkg.sv
// Shared fetch-stage definitions: FSM state encoding and PC geometry.
package fetch_sequencer_pkg;
    localparam int XLEN        = 64;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2
    } fetch_state_t;
endpackage

// File: rtl/redirect_pending_reg.sv
// Holds a redirect that arrived while a fetch was outstanding; a later set overwrites it.
module redirect_pending_reg #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            set,
    input  logic [XLEN-1:0] set_target,
    input  logic            clr,
    output logic            pend_valid,
    output logic [XLEN-1:0] pend_target
);
    logic            pend_valid_q, pend_valid_d;
    logic [XLEN-1:0] pend_target_q, pend_target_d;

    always_comb begin
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        if (set) begin
            pend_valid_d  = 1'b1;
            pend_target_d = set_target;
        end else if (clr) begin
            pend_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
        end else begin
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

    assign pend_valid  = pend_valid_q;
    assign pend_target = pend_target_q;
endmodule

// File: rtl/fetch_sequencer.sv
// PC update and instruction-memory fetch handshake controller with IF/ID write/flush control.
module fetch_sequencer #(
    parameter int XLEN        = fetch_sequencer_pkg::XLEN,
    parameter int INSTR_BYTES = fetch_sequencer_pkg::INSTR_BYTES
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_current,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            imem_ready,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    output logic [XLEN-1:0] pc_next,
    output logic            pc_write,
    output logic            if_id_write,
    output logic            if_id_flush,
    output logic            fetch_valid
);
    import fetch_sequencer_pkg::*;

    fetch_state_t    state_q, state_d;
    logic            pend_set, pend_clr, pend_valid;
    logic [XLEN-1:0] pend_target;
    logic [XLEN-1:0] pc_seq;

    // Modulo 2^XLEN increment: the top aligned address wraps to 0.
    assign pc_seq = pc_current + XLEN'(INSTR_BYTES);

    redirect_pending_reg #(.XLEN(XLEN)) u_pend (
        .clk         (clk),
        .reset       (reset),
        .set         (pend_set),
        .set_target  (redirect_target),
        .clr         (pend_clr),
        .pend_valid  (pend_valid),
        .pend_target (pend_target)
    );

    always_comb begin
        state_d     = state_q;
        pc_next     = pc_current;
        imem_addr   = pc_current;
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        if_id_flush = 1'b0;
        fetch_valid = 1'b0;
        imem_req    = 1'b0;
        pend_set    = 1'b0;
        pend_clr    = 1'b0;
        case (state_q)
            S_BOOT: state_d = S_FETCH;
            S_FETCH: begin
                if (redirect_valid) begin
                    pc_next     = redirect_target;
                    pc_write    = 1'b1;
                    if_id_flush = 1'b1;
                end else if (!stall) begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        pc_next     = pc_seq;
                        pc_write    = 1'b1;
                        if_id_write = 1'b1;
                        fetch_valid = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // Request and address stay up until completion; PC is untouched meanwhile.
                imem_req = 1'b1;
                if (!imem_ready) begin
                    pend_set = redirect_valid;
                end else begin
                    state_d = S_FETCH;
                    if (redirect_valid || pend_valid) begin
                        pc_next     = redirect_valid ? redirect_target : pend_target;
                        pc_write    = 1'b1;
                        if_id_flush = 1'b1;
                        pend_clr    = 1'b1;
                    end else if (!stall) begin
                        pc_next     = pc_seq;
                        pc_write    = 1'b1;
                        if_id_write = 1'b1;
                        fetch_valid = 1'b1;
                    end
                end
            end
            default: state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_BOOT;
        else       state_q <= state_d;
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed scoreboard bench for fetch_sequencer: stimulus pushes expected outputs, a monitor pops and compares.
module tb_fetch_sequencer;
    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic [XLEN-1:0] pc_current;
    logic            stall;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic            imem_ready;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] pc_next;
    logic            pc_write;
    logic            if_id_write;
    logic            if_id_flush;
    logic            fetch_valid;

    typedef struct {
        string           name;
        logic            req;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] nxt;
        logic            pw;
        logic            idw;
        logic            fl;
        logic            fv;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(.XLEN(XLEN), .INSTR_BYTES(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .pc_current      (pc_current),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_ready      (imem_ready),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .pc_next         (pc_next),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .if_id_flush     (if_id_flush),
        .fetch_valid     (fetch_valid)
    );

    // Monitor: outputs are valid every cycle once an expectation exists for it.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_checks++;
            if (imem_req === e.req && imem_addr === e.addr && pc_next === e.nxt &&
                pc_write === e.pw && if_id_write === e.idw && if_id_flush === e.fl &&
                fetch_valid === e.fv) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got req=%b addr=%h next=%h pw=%b idw=%b fl=%b fv=%b want req=%b addr=%h next=%h pw=%b idw=%b fl=%b fv=%b",
                         e.name, imem_req, imem_addr, pc_next, pc_write, if_id_write, if_id_flush, fetch_valid,
                         e.req, e.addr, e.nxt, e.pw, e.idw, e.fl, e.fv);
            end
        end
    end

    task automatic cyc(input string nm, input logic rst, input logic [XLEN-1:0] pc,
                       input logic stl, input logic rv, input logic [XLEN-1:0] rt, input logic rdy,
                       input logic e_req, input logic [XLEN-1:0] e_addr, input logic [XLEN-1:0] e_next,
                       input logic e_pw, input logic e_idw, input logic e_fl, input logic e_fv);
        exp_t e;
        reset           = rst;
        pc_current      = pc;
        stall           = stl;
        redirect_valid  = rv;
        redirect_target = rt;
        imem_ready      = rdy;
        e.name = nm; e.req = e_req; e.addr = e_addr; e.nxt = e_next;
        e.pw = e_pw; e.idw = e_idw; e.fl = e_fl; e.fv = e_fv;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    localparam logic [XLEN-1:0] TOP = 64'hFFFF_FFFF_FFFF_FFFC;

    initial begin
        reset = 1'b1; pc_current = '0; stall = 1'b0; redirect_valid = 1'b0;
        redirect_target = '0; imem_ready = 1'b1;
        @(posedge clk); #1;
        //     name            rst pc       stl rv rt      rdy  req addr     next     pw idw fl fv
        cyc("reset_1",         1, 64'h0,    0, 0, 64'h0,   1,   0, 64'h0,   64'h0,   0, 0, 0, 0);
        cyc("reset_2",         1, 64'h0,    0, 0, 64'h0,   1,   0, 64'h0,   64'h0,   0, 0, 0, 0);
        cyc("boot_idle",       0, 64'h0,    0, 0, 64'h0,   1,   0, 64'h0,   64'h0,   0, 0, 0, 0);
        cyc("first_fetch",     0, 64'h0,    0, 0, 64'h0,   1,   1, 64'h0,   64'h4,   1, 1, 0, 1);
        cyc("wait_c1",         0, 64'h100,  0, 0, 64'h0,   0,   1, 64'h100, 64'h100, 0, 0, 0, 0);
        cyc("wait_c2",         0, 64'h100,  0, 0, 64'h0,   0,   1, 64'h100, 64'h100, 0, 0, 0, 0);
        cyc("wait_c3_done",    0, 64'h100,  0, 0, 64'h0,   1,   1, 64'h100, 64'h104, 1, 1, 0, 1);
        cyc("redir_fetch",     0, 64'h104,  1, 1, 64'h2000,1,   0, 64'h104, 64'h2000,1, 0, 1, 0);
        cyc("stall_fetch",     0, 64'h2000, 1, 0, 64'h0,   1,   0, 64'h2000,64'h2000,0, 0, 0, 0);
        cyc("wredir_issue",    0, 64'h2000, 0, 0, 64'h0,   0,   1, 64'h2000,64'h2000,0, 0, 0, 0);
        cyc("wredir_40",       0, 64'h2000, 0, 1, 64'h40,  0,   1, 64'h2000,64'h2000,0, 0, 0, 0);
        cyc("wredir_80",       0, 64'h2000, 0, 1, 64'h80,  0,   1, 64'h2000,64'h2000,0, 0, 0, 0);
        cyc("wredir_hold",     0, 64'h2000, 0, 0, 64'h0,   0,   1, 64'h2000,64'h2000,0, 0, 0, 0);
        cyc("wredir_done",     0, 64'h2000, 0, 0, 64'h0,   1,   1, 64'h2000,64'h80,  1, 0, 1, 0);
        cyc("pend_clr_issue",  0, 64'h80,   0, 0, 64'h0,   0,   1, 64'h80,  64'h80,  0, 0, 0, 0);
        cyc("pend_clr_seq",    0, 64'h80,   0, 0, 64'h0,   1,   1, 64'h80,  64'h84,  1, 1, 0, 1);
        cyc("live_issue",      0, 64'h84,   0, 0, 64'h0,   0,   1, 64'h84,  64'h84,  0, 0, 0, 0);
        cyc("live_pend",       0, 64'h84,   0, 1, 64'h500, 0,   1, 64'h84,  64'h84,  0, 0, 0, 0);
        cyc("live_wins",       0, 64'h84,   0, 1, 64'h600, 1,   1, 64'h84,  64'h600, 1, 0, 1, 0);
        cyc("wstall_issue",    0, 64'h600,  0, 0, 64'h0,   0,   1, 64'h600, 64'h600, 0, 0, 0, 0);
        cyc("wstall_done",     0, 64'h600,  1, 0, 64'h0,   1,   1, 64'h600, 64'h600, 0, 0, 0, 0);
        cyc("wstall_refetch",  0, 64'h600,  0, 0, 64'h0,   1,   1, 64'h600, 64'h604, 1, 1, 0, 1);
        cyc("pc_wrap",         0, TOP,      0, 0, 64'h0,   1,   1, TOP,     64'h0,   1, 1, 0, 1);
        cyc("rst_wait_issue",  0, 64'h300,  0, 0, 64'h0,   0,   1, 64'h300, 64'h300, 0, 0, 0, 0);
        cyc("rst_wait_edge",   1, 64'h300,  0, 0, 64'h0,   0,   1, 64'h300, 64'h300, 0, 0, 0, 0);
        cyc("rst_abandoned",   0, 64'h300,  0, 0, 64'h0,   1,   0, 64'h300, 64'h300, 0, 0, 0, 0);
        cyc("post_rst_fetch",  0, 64'h300,  0, 0, 64'h0,   1,   1, 64'h300, 64'h304, 1, 1, 0, 1);
        @(negedge clk); #1;
        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
